// File: rtl/sort_scheduler.sv
// Two-requester front end for an external 8-value sorter: arbitrates, streams a batch in, returns the sorted word.
// Optional macro SORT_TIMEOUT_EN bounds the sorter wait and flags an error response on expiry.
module sort_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [31:0] req0_data,
    input  logic [31:0] req1_data,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp0_data,
    output logic [31:0] rsp1_data,
    output logic        rsp0_err,
    output logic        rsp1_err,
    input  logic        rsp0_ready,
    input  logic        rsp1_ready,
    output logic        s_enter,
    output logic [3:0]  s_in,
    input  logic        s_done,
    input  logic [3:0]  s_lt,
    input  logic [3:0]  s_lo,
    input  logic [3:0]  s_lm,
    input  logic [3:0]  s_me,
    input  logic [3:0]  s_mh,
    input  logic [3:0]  s_hi,
    input  logic [3:0]  s_hr,
    input  logic [3:0]  s_ht,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic [31:0] batch, batch_nx;
    logic [31:0] result, result_nx;
    logic [2:0]  k, k_nx;
    logic        gid, gid_nx;
    logic        last, last_nx;
    logic        grant_any;
    logic        grant_id;
    logic        rsp_hs;
`ifdef SORT_TIMEOUT_EN
    logic [7:0]  tmo, tmo_nx;
    logic        err, err_nx;
`endif

    // Tie goes to whoever was not served last.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid)
            grant_id = ~last;
        else
            grant_id = req1_valid;
    end

    always_comb begin
        state_nx   = state;
        batch_nx   = batch;
        result_nx  = result;
        k_nx       = k;
        gid_nx     = gid;
        last_nx    = last;
`ifdef SORT_TIMEOUT_EN
        tmo_nx     = tmo;
        err_nx     = err;
`endif
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        s_enter    = 1'b0;
        s_in       = '0;
        rsp_hs     = gid ? rsp1_ready : rsp0_ready;

        unique case (state)
            IDLE: begin
                if (grant_any) begin
                    // Ready is combinational, so it must be gated while reset is asserted.
                    req0_ready = rst & ~grant_id;
                    req1_ready = rst & grant_id;
                    batch_nx   = grant_id ? req1_data : req0_data;
                    gid_nx     = grant_id;
                    k_nx       = '0;
                    state_nx   = LOAD;
                end
            end
            LOAD: begin
                s_enter = (k == 3'd0);
                s_in    = batch[{k, 2'b00} +: 4];
                k_nx    = k + 3'd1;
                if (k == 3'd7) begin
                    state_nx = WAIT;
`ifdef SORT_TIMEOUT_EN
                    tmo_nx   = '0;
`endif
                end
            end
            WAIT: begin
                if (s_done) begin
                    result_nx = {s_ht, s_hr, s_hi, s_mh, s_me, s_lm, s_lo, s_lt};
`ifdef SORT_TIMEOUT_EN
                    err_nx    = 1'b0;
`endif
                    state_nx  = RESP;
                end
`ifdef SORT_TIMEOUT_EN
                // Leave on the edge where the counter would reach 255.
                else if (tmo == 8'd254) begin
                    result_nx = '0;
                    err_nx    = 1'b1;
                    state_nx  = RESP;
                end else begin
                    tmo_nx = tmo + 8'd1;
                end
`endif
            end
            RESP: begin
                if (rsp_hs) begin
                    last_nx  = gid;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            batch  <= '0;
            result <= '0;
            k      <= '0;
            gid    <= 1'b0;
            last   <= 1'b1;
`ifdef SORT_TIMEOUT_EN
            tmo    <= '0;
            err    <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            batch  <= batch_nx;
            result <= result_nx;
            k      <= k_nx;
            gid    <= gid_nx;
            last   <= last_nx;
`ifdef SORT_TIMEOUT_EN
            tmo    <= tmo_nx;
            err    <= err_nx;
`endif
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        rsp0_valid = (state == RESP) && !gid;
        rsp1_valid = (state == RESP) && gid;
        rsp0_data  = rsp0_valid ? result : '0;
        rsp1_data  = rsp1_valid ? result : '0;
`ifdef SORT_TIMEOUT_EN
        rsp0_err   = rsp0_valid & err;
        rsp1_err   = rsp1_valid & err;
`else
        rsp0_err   = 1'b0;
        rsp1_err   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_sort_scheduler.sv
// Directed plus randomized bench for sort_scheduler; the sorter is modelled by sorting each batch in the bench.
module tb_sort_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_err, rsp1_err;
    logic        rsp0_ready, rsp1_ready;
    logic        s_enter;
    logic [3:0]  s_in;
    logic        s_done;
    logic [3:0]  s_lt, s_lo, s_lm, s_me, s_mh, s_hi, s_hr, s_ht;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int last    = 1;

    sort_scheduler dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_data(rsp0_data), .rsp1_data(rsp1_data),
        .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .s_enter(s_enter), .s_in(s_in), .s_done(s_done),
        .s_lt(s_lt), .s_lo(s_lo), .s_lm(s_lm), .s_me(s_me),
        .s_mh(s_mh), .s_hi(s_hi), .s_hr(s_hr), .s_ht(s_ht),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ctl_vec();
        return 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
                    s_enter, s_in, busy});
    endfunction

    // Reference sorter: ascending order, smallest value in the low nibble.
    function automatic logic [31:0] sort_pack(input logic [31:0] d);
        int q[$];
        logic [31:0] r;
        for (int i = 0; i < 8; i++) q.push_back(int'(d[4*i +: 4]));
        q.sort();
        r = '0;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'(q[i]);
        return r;
    endfunction

    function automatic int arb(input bit v0, input bit v1);
        if (v0 && v1) return (last == 0) ? 1 : 0;
        return v1 ? 1 : 0;
    endfunction

    task automatic set_sorter(input logic [31:0] p);
        s_lt = p[3:0];   s_lo = p[7:4];   s_lm = p[11:8];  s_me = p[15:12];
        s_mh = p[19:16]; s_hi = p[23:20]; s_hr = p[27:24]; s_ht = p[31:28];
    endtask

    task automatic accept_load(input int id, input logic [31:0] d, input bit early);
        int n;
        logic [3:0] nib;
        n = 0;
        #1;
        while (!(req0_ready || req1_ready) && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check("grant", 32'({req1_ready, req0_ready}), (id == 0) ? 32'd1 : 32'd2);
        @(posedge clk); #1;
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            nib = d[4*k +: 4];
            check($sformatf("load%0d", k), 32'({busy, req1_ready, req0_ready, s_enter, s_in}),
                  32'({1'b1, 1'b0, 1'b0, (k == 0), nib}));
            if (early && k == 3) begin
                s_done = 1'b1;
                set_sorter($urandom);
            end
            if (early && k == 4) s_done = 1'b0;
        end
    endtask

    task automatic finish_rsp(input int id);
        rsp0_ready = (id == 0);
        rsp1_ready = (id == 1);
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check("post_hs", 32'({busy, rsp1_valid, rsp0_valid}), 32'd0);
        @(negedge clk);
    endtask

    task automatic serve(input int id, input logic [31:0] d, input int dly, input int hold, input bit early);
        logic [31:0] srt;
        bit ok;
        srt = sort_pack(d);
        accept_load(id, d, early);
        set_sorter(srt);
        ok = 1'b1;
        @(negedge clk);
        repeat (dly) begin
            ok = ok && !rsp0_valid && !rsp1_valid && busy;
            @(negedge clk);
        end
        check("wait_quiet", 32'(ok), 32'd1);
        s_done = 1'b1;
        @(negedge clk);
        s_done = 1'b0;
        set_sorter($urandom);
        check("rsp_valid", 32'({rsp1_valid, rsp0_valid}), (id == 0) ? 32'd1 : 32'd2);
        check("rsp_data", (id == 0) ? rsp0_data : rsp1_data, srt);
        check("rsp_err", 32'({rsp1_err, rsp0_err}), 32'd0);
        // The idle requester's rsp_ready is held high to show it has no effect.
        rsp0_ready = (id == 1);
        rsp1_ready = (id == 0);
        ok = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            ok = ok && !req0_ready && !req1_ready &&
                 (((id == 0) ? rsp0_valid : rsp1_valid) === 1'b1) &&
                 (((id == 0) ? rsp0_data : rsp1_data) === srt);
        end
        check("rsp_hold", 32'(ok), 32'd1);
        finish_rsp(id);
    endtask

    initial begin
        logic [31:0] da, db;
        int g, v;
        bit ok;

        rst = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = $urandom; req1_data = $urandom;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        s_done = 1'b0;
        set_sorter('0);
        repeat (3) @(negedge clk);
        check("rst_ctl", ctl_vec(), 32'd0);
        check("rst_data", rsp0_data | rsp1_data, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("idle", 32'(busy), 32'd0);

        // Simultaneous requests after reset: requester 0 first.
        da = $urandom; db = $urandom;
        req0_data = da; req1_data = db;
        req0_valid = 1'b1; req1_valid = 1'b1;
        serve(0, da, 1, 3, 1'b0); last = 0;
        serve(1, db, 0, 0, 1'b0); last = 1;

        // Known batch, response held 20 cycles with requester 1 waiting.
        db = $urandom;
        req0_data = 32'h6EA5F017; req1_data = db;
        req0_valid = 1'b1; req1_valid = 1'b1;
        g = arb(1'b1, 1'b1);
        serve(g, 32'h6EA5F017, 2, 20, 1'b0); last = g;
        serve(1 - g, db, 3, 1, 1'b0); last = 1 - g;

        // s_done during LOAD must be ignored.
        da = $urandom;
        req0_data = da; req0_valid = 1'b1;
        serve(0, da, 4, 2, 1'b1); last = 0;

        // Reset in LOAD k = 4 abandons the batch.
        da = $urandom;
        req0_data = da; req0_valid = 1'b1;
        #1;
        check("rl_grant", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("rl_k4", 32'({s_enter, s_in}), 32'({1'b0, da[19:16]}));
        rst = 1'b0;
        #1;
        check("rl_ctl", ctl_vec(), 32'd0);
        check("rl_data", rsp0_data | rsp1_data, 32'd0);
        last = 1;
        da = $urandom;
        req0_data = da; req0_valid = 1'b1;
        @(negedge clk);
        check("rl_hold", ctl_vec(), 32'd0);
        rst = 1'b1;
        serve(0, da, 1, 1, 1'b0); last = 0;

        // Sorter never finishes.
        da = $urandom;
        req0_data = da; req0_valid = 1'b1;
        accept_load(0, da, 1'b0);
        ok = 1'b1;
`ifdef SORT_TIMEOUT_EN
        repeat (255) begin
            @(negedge clk);
            ok = ok && !rsp0_valid && busy;
        end
        check("tmo_wait", 32'(ok), 32'd1);
        @(negedge clk);
        check("tmo_rsp", 32'({rsp1_valid, rsp0_valid, rsp0_err}), 32'b011);
        check("tmo_data", rsp0_data, 32'd0);
        finish_rsp(0); last = 0;
`else
        repeat (300) begin
            @(negedge clk);
            ok = ok && !rsp0_valid && busy;
        end
        check("no_tmo", 32'(ok), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        last = 1;
        @(negedge clk);
`endif

        // Randomized traffic against the arbitration and sort model.
        for (int it = 0; it < 24; it++) begin
            v = int'($urandom_range(1, 3));
            da = $urandom; db = $urandom;
            req0_data = da; req1_data = db;
            req0_valid = v[0]; req1_valid = v[1];
            g = arb(v[0], v[1]);
            serve(g, (g == 0) ? da : db, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                  1'($urandom_range(0, 1)));
            last = g;
            if (v == 3) begin
                serve(1 - g, (g == 0) ? db : da, int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 4)), 1'b0);
                last = 1 - g;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sort_scheduler.md
SORT_SCHEDULER -- requirements
Module: sort_scheduler

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 The block SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester N has a batch to sort.
REQ-004 The block SHALL have ports req0_data / req1_data, input, 32 bits each: eight 4-bit values, value k at bits [4k+3:4k], value 0 loaded first.
REQ-005 The block SHALL have ports req0_ready / req1_ready, output, 1 bit each: one-cycle accept pulse; batch latched on that edge.
REQ-006 The block SHALL have ports rsp0_valid / rsp1_valid, output, 1 bit each: sorted result available for requester N.
REQ-007 The block SHALL have ports rsp0_data / rsp1_data, output, 32 bits each: sorted result, bits [3:0] = s_lt … bits [31:28] = s_ht.
REQ-008 The block SHALL have ports rsp0_err / rsp1_err, output, 1 bit each: result invalid (timeout); qualified by rspN_valid.
REQ-009 The block SHALL have ports rsp0_ready / rsp1_ready, input, 1 bit each: requester N consumes the result.
REQ-010 The block SHALL have ports s_enter, output, 1 bit, and s_in, output, 4 bits: sorter load controls.
REQ-011 The block SHALL have port s_done, input, 1 bit: sorter finished.
REQ-012 The block SHALL have ports s_lt, s_lo, s_lm, s_me, s_mh, s_hi, s_hr, s_ht, input, 4 bits each: sorter outputs, lowest to highest.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, LOAD, WAIT, RESP.
REQ-015 IDLE, no reqN_valid: the FSM SHALL stay in IDLE.
REQ-016 IDLE, exactly one reqN_valid: the FSM SHALL grant requester N.
REQ-017 IDLE, both reqN_valid: the FSM SHALL grant the requester not served last (round-robin); after reset, requester 0 wins the first tie.
REQ-018 On grant the FSM SHALL pulse reqN_ready for one cycle, latch reqN_data and the grant ID, clear the 3-bit load counter and enter LOAD.
REQ-019 In LOAD, cycle k (k = 0..7), s_in SHALL equal latched value k.
REQ-020 In LOAD, s_enter SHALL be 1 only at k = 0 and 0 otherwise.
REQ-021 After k = 7 the FSM SHALL enter WAIT; LOAD SHALL last exactly 8 cycles.
REQ-022 Outside LOAD, s_enter and s_in SHALL be 0.
REQ-023 In WAIT, on s_done = 1 the FSM SHALL capture s_lt..s_ht into the result register, clear err and enter RESP.
REQ-024 s_done SHALL be ignored in every state except WAIT.
REQ-025 In RESP, rspN_valid SHALL be asserted for the granted N only, with data and err held stable until rspN_ready = 1.
REQ-026 On the RESP handshake the FSM SHALL record N as last served and return to IDLE; no grant SHALL be issued in the handshake cycle.
REQ-027 reqN_valid SHALL be ignored outside IDLE; no reqN_ready SHALL be issued while busy.
REQ-028 The rsp_ready of the non-granted requester SHALL have no effect.
REQ-029 Latency: with accept edge T, LOAD SHALL occupy cycles T+1..T+8, and rspN_valid SHALL rise on the first edge after the s_done sample in WAIT.

Reset
REQ-030 When rst = 0 the block SHALL immediately force state IDLE and last-served = requester 1.
REQ-031 When rst = 0 all outputs (reqN_ready, rspN_valid, rspN_data, rspN_err, s_enter, s_in, busy) SHALL be forced to 0.
REQ-032 Reset asserted mid-LOAD or mid-WAIT SHALL abandon the batch and produce no response; the block SHALL resume in IDLE on the first edge after rst rises.

Configuration
REQ-033 With macro SORT_TIMEOUT_EN defined, an 8-bit counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-034 With SORT_TIMEOUT_EN defined, if the counter reaches 255 without s_done, the FSM SHALL enter RESP with rspN_data = 0 and rspN_err = 1.
REQ-035 With SORT_TIMEOUT_EN undefined, WAIT SHALL be unbounded and rspN_err SHALL be tied to 0.

Verification
REQ-036 The bench SHALL cover: req0_data = 0x6EA5F017 -> s_in sequence 7,1,0,F,5,A,E,6 with s_enter high on the first cycle only; sorter model done -> rsp0_data = 0xFEA76510, rsp0_err = 0.
REQ-037 The bench SHALL cover: req0 and req1 valid together after reset -> req0 granted first; req1 granted on the next IDLE; rsp1 carries req1's sorted data.
REQ-038 The bench SHALL cover: rsp0_ready held 0 for 20 cycles -> rsp0_valid and rsp0_data stable; no req1_ready pulse during that time.
REQ-039 The bench SHALL cover: rst pulsed low in LOAD cycle k = 4 -> outputs 0 immediately; no rsp; next request is processed normally.
REQ-040 The bench SHALL cover: with SORT_TIMEOUT_EN, s_done never asserted -> rsp0_valid with err = 1 and data = 0 after 255 WAIT cycles.
REQ-041 The bench SHALL cover: s_done pulsed during LOAD -> ignored; WAIT still waits for a fresh s_done.
